// File: rtl/huffman_decoder_pkg.sv
// Shared constants, table types and state encoding for the 6-symbol Huffman decoder.
package huffman_decoder_pkg;
    localparam int CW   = 8;
    localparam int NSYM = 6;
    localparam int SYMW = 3;
    localparam int LW   = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_ERR} state_t;

    typedef logic [NSYM-1:0][CW-1:0] code_tbl_t;
    typedef logic [NSYM-1:0][LW-1:0] len_tbl_t;

    function automatic logic [LW-1:0] popcount(input logic [CW-1:0] m);
        logic [LW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < CW; i++) begin
            cnt = cnt + LW'(m[i]);
        end
        return cnt;
    endfunction
endpackage

// File: rtl/huffman_decoder_match.sv
// Combinational 6-way code comparator; lowest symbol index wins when a malformed table matches twice.
module huffman_decoder_match
    import huffman_decoder_pkg::*;
(
    input  logic [CW-1:0]   i_shreg_n,
    input  logic [LW-1:0]   i_len_n,
    input  code_tbl_t       i_code_tbl,
    input  code_tbl_t       i_mask_tbl,
    input  len_tbl_t        i_len_tbl,
    output logic            o_hit,
    output logic [SYMW-1:0] o_idx
);
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        // Scan downwards so the lowest matching index is the one left standing.
        for (int i = NSYM - 1; i >= 0; i--) begin
            if (i_len_tbl[i] != '0 && i_len_tbl[i] == i_len_n &&
                (i_shreg_n & i_mask_tbl[i]) == i_code_tbl[i]) begin
                o_hit = 1'b1;
                o_idx = SYMW'(i + 1);
            end
        end
    end
endmodule

// File: rtl/huffman_decoder.sv
// Serial MSB-first Huffman decoder: 1-cycle latency from the final code bit to sym_valid.
// Bit input stalls while a symbol waits for the consumer; a table load wins over flush and bits.
module huffman_decoder
    import huffman_decoder_pkg::*;
#(
    parameter int SCW = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_code_valid,
    input  logic [CW-1:0]   i_hc1,
    input  logic [CW-1:0]   i_hc2,
    input  logic [CW-1:0]   i_hc3,
    input  logic [CW-1:0]   i_hc4,
    input  logic [CW-1:0]   i_hc5,
    input  logic [CW-1:0]   i_hc6,
    input  logic [CW-1:0]   i_m1,
    input  logic [CW-1:0]   i_m2,
    input  logic [CW-1:0]   i_m3,
    input  logic [CW-1:0]   i_m4,
    input  logic [CW-1:0]   i_m5,
    input  logic [CW-1:0]   i_m6,
    input  logic            i_flush,
    input  logic            i_bit_valid,
    input  logic            i_bit_in,
    output logic            o_bit_ready,
    output logic            o_sym_valid,
    output logic [SYMW-1:0] o_sym,
    input  logic            i_sym_ready,
    output logic            o_err,
    output logic [SCW-1:0]  o_sym_count
);
    state_t          r_state;
    logic [CW-1:0]   r_shreg;
    logic [LW-1:0]   r_len;
    code_tbl_t       r_code;
    code_tbl_t       r_mask;
    len_tbl_t        r_lens;
    logic            r_sym_valid;
    logic [SYMW-1:0] r_sym;
    logic            r_err;
    logic [SCW-1:0]  r_sym_count;

    logic            w_bit_ready;
    logic            w_accept;
    logic            w_retire;
    logic [CW-1:0]   w_shreg_n;
    logic [LW-1:0]   w_len_n;
    logic            w_hit;
    logic [SYMW-1:0] w_idx;
    code_tbl_t       w_hc_in;
    code_tbl_t       w_m_in;

    assign w_hc_in = {i_hc6, i_hc5, i_hc4, i_hc3, i_hc2, i_hc1};
    assign w_m_in  = {i_m6, i_m5, i_m4, i_m3, i_m2, i_m1};

    assign w_bit_ready = (r_state == ST_RUN) && !i_code_valid && (!r_sym_valid || i_sym_ready);
    assign w_accept    = i_bit_valid && w_bit_ready;
    assign w_retire    = r_sym_valid && i_sym_ready;
    assign w_shreg_n   = {r_shreg[CW-2:0], i_bit_in};
    assign w_len_n     = r_len + 1'b1;

    huffman_decoder_match u_match (
        .i_shreg_n  (w_shreg_n),
        .i_len_n    (w_len_n),
        .i_code_tbl (r_code),
        .i_mask_tbl (r_mask),
        .i_len_tbl  (r_lens),
        .o_hit      (w_hit),
        .o_idx      (w_idx)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_len       <= '0;
            r_code      <= '0;
            r_mask      <= '0;
            r_lens      <= '0;
            r_sym_valid <= 1'b0;
            r_sym       <= '0;
            r_err       <= 1'b0;
            r_sym_count <= '0;
        end else if (i_code_valid) begin
            r_state     <= ST_RUN;
            r_code      <= w_hc_in;
            r_mask      <= w_m_in;
            for (int i = 0; i < NSYM; i++) begin
                r_lens[i] <= popcount(w_m_in[i]);
            end
            r_shreg     <= '0;
            r_len       <= '0;
            r_sym_valid <= 1'b0;
            r_err       <= 1'b0;
            r_sym_count <= '0;
        end else begin
            if (w_retire) begin
                r_sym_valid <= 1'b0;
                r_sym_count <= r_sym_count + 1'b1;
            end
            // Flush drops any bit accepted in the same cycle.
            if (i_flush) begin
                r_shreg <= '0;
                r_len   <= '0;
            end else if (w_accept) begin
                if (w_hit) begin
                    r_sym_valid <= 1'b1;
                    r_sym       <= w_idx;
                    r_shreg     <= '0;
                    r_len       <= '0;
                end else if (w_len_n == LW'(CW)) begin
                    r_state <= ST_ERR;
                    r_err   <= 1'b1;
                    r_shreg <= '0;
                    r_len   <= '0;
                end else begin
                    r_shreg <= w_shreg_n;
                    r_len   <= w_len_n;
                end
            end
        end
    end

    assign o_bit_ready = w_bit_ready;
    assign o_sym_valid = r_sym_valid;
    assign o_sym       = r_sym;
    assign o_err       = r_err;
    assign o_sym_count = r_sym_count;
endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder using the reference 0/10/110/1110/11110/11111 code table.
module tb_huffman_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        code_valid = 1'b0;
    logic [7:0]  hc [6];
    logic [7:0]  m  [6];
    logic        flush = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_ready;
    logic        sym_valid;
    logic [2:0]  sym;
    logic        sym_ready = 1'b0;
    logic        err;
    logic [15:0] sym_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    huffman_decoder #(.SCW(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_code_valid(code_valid),
        .i_hc1(hc[0]), .i_hc2(hc[1]), .i_hc3(hc[2]), .i_hc4(hc[3]), .i_hc5(hc[4]), .i_hc6(hc[5]),
        .i_m1(m[0]), .i_m2(m[1]), .i_m3(m[2]), .i_m4(m[3]), .i_m5(m[4]), .i_m6(m[5]),
        .i_flush(flush), .i_bit_valid(bit_valid), .i_bit_in(bit_in), .o_bit_ready(bit_ready),
        .o_sym_valid(sym_valid), .o_sym(sym), .i_sym_ready(sym_ready), .o_err(err),
        .o_sym_count(sym_count)
    );

    task automatic set_ref_table();
        hc = '{8'h00, 8'h02, 8'h06, 8'h0E, 8'h1E, 8'h1F};
        m  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F};
    endtask

    task automatic load_table();
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_tests++;
        if (sym_valid !== 1'b0 || sym !== 3'd0 || err !== 1'b0 || sym_count !== 16'd0 || bit_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: sym_valid=%b sym=%0d err=%b count=%0d bit_ready=%b, need all 0",
                     sym_valid, sym, err, sym_count, bit_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        bit_valid = 1'b1;
        #1;
        n_tests++;
        if (bit_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ready: bit_ready=%b, need 0 before any table load", bit_ready);
        end
        bit_valid = 1'b0;
    endtask

    task automatic test_decode();
        logic [7:0] bits;
        logic       ev [8];
        logic [2:0] es [8];
        bits = 8'b1001_1111;
        ev = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        es = '{3'd0, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6};
        set_ref_table();
        load_table();
        sym_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bit_valid = 1'b1;
            bit_in    = bits[7-i];
            #1;
            n_tests++;
            if (bit_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL decode_ready bit %0d: bit_ready=%b, need 1", i, bit_ready);
            end
            @(negedge clk);
            n_tests++;
            if (sym_valid !== ev[i] || (ev[i] && sym !== es[i])) begin
                n_fail++;
                $display("FAIL decode_sym bit %0d: sym_valid=%b sym=%0d, need sym_valid=%b sym=%0d",
                         i, sym_valid, sym, ev[i], es[i]);
            end
        end
        bit_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (sym_count !== 16'd3 || err !== 1'b0 || sym_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL decode_count: count=%0d err=%b sym_valid=%b, need 3/0/0", sym_count, err, sym_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] rest;
        rest = 6'b011111;
        set_ref_table();
        load_table();
        sym_ready = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (bit_ready !== 1'b0 || sym_valid !== 1'b1 || sym !== 3'd2) begin
                n_fail++;
                $display("FAIL stall cycle %0d: bit_ready=%b sym_valid=%b sym=%0d, need 0/1/2",
                         i, bit_ready, sym_valid, sym);
            end
            @(negedge clk);
        end
        sym_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bit_valid = 1'b1;
            bit_in    = rest[5-i];
            @(negedge clk);
            if (i == 0) begin
                n_tests++;
                if (sym_valid !== 1'b1 || sym !== 3'd1) begin
                    n_fail++;
                    $display("FAIL release_sym: sym_valid=%b sym=%0d, need 1/1", sym_valid, sym);
                end
            end
        end
        bit_valid = 1'b0;
        n_tests++;
        if (sym_valid !== 1'b1 || sym !== 3'd6 || sym_count !== 16'd2) begin
            n_fail++;
            $display("FAIL release_last: sym_valid=%b sym=%0d count=%0d, need 1/6/2", sym_valid, sym, sym_count);
        end
        @(negedge clk);
    endtask

    task automatic test_error();
        hc = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        m  = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_table();
        sym_ready = 1'b1;
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        n_tests++;
        if (err !== 1'b0 || sym_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL err_early: err=%b sym_valid=%b after 7 bits, need 0/0", err, sym_valid);
        end
        send_bit(1'b1);
        bit_valid = 1'b1;
        #1;
        n_tests++;
        if (err !== 1'b1 || bit_ready !== 1'b0 || sym_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL err_set: err=%b bit_ready=%b sym_valid=%b, need 1/0/0", err, bit_ready, sym_valid);
        end
        bit_valid = 1'b0;
        @(negedge clk);
        set_ref_table();
        load_table();
        #1;
        n_tests++;
        if (err !== 1'b0 || bit_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL err_reload: err=%b bit_ready=%b, need 0/1", err, bit_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        set_ref_table();
        load_table();
        sym_ready = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        send_bit(1'b0);
        n_tests++;
        if (sym_valid !== 1'b1 || sym !== 3'd1) begin
            n_fail++;
            $display("FAIL flush_sym: sym_valid=%b sym=%0d, need 1/1", sym_valid, sym);
        end
        send_bit(1'b1);
        flush     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        @(negedge clk);
        flush     = 1'b0;
        bit_valid = 1'b0;
        n_tests++;
        if (sym_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drop: sym_valid=%b, need 0 (bit under flush must be dropped)", sym_valid);
        end
        send_bit(1'b0);
        n_tests++;
        if (sym_valid !== 1'b1 || sym !== 3'd1 || sym_count !== 16'd1) begin
            n_fail++;
            $display("FAIL flush_prio: sym_valid=%b sym=%0d count=%0d, need 1/1/1", sym_valid, sym, sym_count);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        set_ref_table();
        load_table();
        sym_ready = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        sym_ready = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        bit_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (sym_valid !== 1'b0 || sym !== 3'd0 || err !== 1'b0 || sym_count !== 16'd0 || bit_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset: sym_valid=%b sym=%0d err=%b count=%0d bit_ready=%b, need all 0",
                     sym_valid, sym, err, sym_count, bit_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bit_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_idle: bit_ready=%b, need 0 until reload", bit_ready);
        end
        sym_ready  = 1'b1;
        bit_in     = 1'b0;
        code_valid = 1'b1;
        #1;
        n_tests++;
        if (bit_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_cycle_ready: bit_ready=%b, need 0 during code_valid", bit_ready);
        end
        @(negedge clk);
        code_valid = 1'b0;
        n_tests++;
        if (sym_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL load_cycle_bit: sym_valid=%b, need 0 (bit under code_valid ignored)", sym_valid);
        end
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        @(negedge clk);
        bit_valid = 1'b0;
        n_tests++;
        if (sym_valid !== 1'b1 || sym !== 3'd1) begin
            n_fail++;
            $display("FAIL post_reset_sym: sym_valid=%b sym=%0d, need 1/1", sym_valid, sym);
        end
        @(negedge clk);
    endtask

    initial begin
        set_ref_table();
        test_reset();
        test_decode();
        test_backpressure();
        test_error();
        test_flush();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
